// File: rtl/nibble_serial_add_ctrl.sv
// Wide adder sequencer: streams operands LS nibble first through one external 4-bit add slice.
// Optional macro SUB_MODE_EN adds a 'sub' input (A-B via inverted B and forced carry-in).
module nibble_serial_add_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_valid,
    output logic                 start_ready,
    input  logic [4*NIBBLES-1:0] op_a,
    input  logic [4*NIBBLES-1:0] op_b,
    input  logic                 cin,
`ifdef SUB_MODE_EN
    input  logic                 sub,
`endif
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [4*NIBBLES-1:0] result,
    output logic                 cout,
    output logic                 busy,
    output logic [3:0]           slice_a,
    output logic [3:0]           slice_b,
    output logic                 slice_cin,
    input  logic [3:0]           slice_sum,
    input  logic                 slice_cout
);
    localparam int W  = 4*NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NIBBLES-1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic [W-1:0]   result_q, result_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic           carry_q, carry_d;
    logic           cout_q, cout_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        result_d  = result_q;
        idx_d     = idx_q;
        carry_d   = carry_q;
        cout_d    = cout_q;
        slice_a   = 4'h0;
        slice_b   = 4'h0;
        slice_cin = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_valid) begin
                    a_d      = op_a;
                    idx_d    = '0;
                    result_d = '0;
`ifdef SUB_MODE_EN
                    // Two's-complement subtract: A + ~B + 1; cout=1 then means no borrow.
                    b_d      = sub ? ~op_b : op_b;
                    carry_d  = sub ? 1'b1 : cin;
`else
                    b_d      = op_b;
                    carry_d  = cin;
`endif
                    state_d  = RUN;
                end
            end
            RUN: begin
                slice_a   = a_q[4*idx_q +: 4];
                slice_b   = b_q[4*idx_q +: 4];
                slice_cin = carry_q;
                result_d[4*idx_q +: 4] = slice_sum;
                carry_d   = slice_cout;
                // idx parks on the last nibble instead of wrapping.
                if (idx_q == LAST) begin
                    cout_d  = slice_cout;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign start_ready = (state_q == IDLE);
    assign res_valid   = (state_q == DONE);
    assign busy        = (state_q != IDLE);
    assign result      = result_q;
    assign cout        = cout_q;

endmodule
